arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 70 +++++++
 1 files changed

// File: rtl/arb_mux.sv
// arb_mux: N:1 channel mux with fixed-select or round-robin grant into a single registered output slot.
module arb_mux #(
  parameter int WIDTH = 18,
  parameter int NUM_IN = 4,
  parameter int MODE = 0,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_channel,
  output logic [15:0]             out_count
);
  logic [SEL_W-1:0] gnt, idx, last_q, last_d, out_channel_q, out_channel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0] out_count_q, out_count_d;
  logic out_valid_q, out_valid_d, gnt_v, space, load;
  // Round-robin scans downward so the channel nearest after last grant is assigned last and wins.
  always_comb begin
    gnt = sel;
    gnt_v = 1'b0;
    idx = '0;
    if (MODE == 0) begin
      gnt_v = (32'(sel) < NUM_IN) && in_valid[sel];
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        idx = SEL_W'((32'(last_q) + 32'(k)) % NUM_IN);
        if (in_valid[idx]) begin
          gnt_v = 1'b1;
          gnt = idx;
        end
      end
    end
  end
  always_comb begin
    space = !out_valid_q || out_ready;
    load = space && gnt_v && !rst;
    in_ready = load ? NUM_IN'(1) << gnt : '0;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d = load ? in_data[gnt*WIDTH +: WIDTH] : out_data_q;
    out_channel_d = load ? gnt : out_channel_q;
    last_d = load ? gnt : last_q;
    out_count_d = out_count_q + 16'(out_valid_q && out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_channel_q <= '0;
      out_count_q <= '0;
      last_q <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_channel_q <= out_channel_d;
      out_count_q <= out_count_d;
      last_q <= last_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_channel = out_channel_q;
  assign out_count = out_count_q;
endmodule
